seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_div_iter.sv | 66 ++++++
 rtl/seq_alu.sv | 123 ++++++++++++
 tb/tb_seq_alu.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROTL = 4'h6,
        OP_ROTR = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_NOR  = 4'hA,
        OP_NAND = 4'hB,
        OP_XOR  = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } op_e;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;
    localparam int unsigned FLAG_DIV0  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring radix-2 unsigned divider, one quotient bit per cycle.
// The first bit is resolved on the start edge, so done rises WIDTH-1 edges later.
module alu_div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [WIDTH-1:0] rem, quo, dvs;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] rem_in, quo_in, dvs_in;
    logic [WIDTH:0]   shifted, diff;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;

    // quo holds the not-yet-consumed dividend bits on top and the quotient bits below
    always_comb begin
        rem_in  = start ? '0 : rem;
        quo_in  = start ? dividend : quo;
        dvs_in  = start ? divisor : dvs;
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_in};
        fits    = shifted >= {1'b0, dvs_in};
        rem_nxt = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nxt = {quo_in[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(1);
            rem  <= rem_nxt;
            quo  <= quo_nxt;
            dvs  <= divisor;
        end else if (busy) begin
            if (cnt == LAST) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + CW'(1);
                rem <= rem_nxt;
                quo <= quo_nxt;
            end
        end
    end

    assign done     = busy && (cnt == LAST);
    assign quotient = quo;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes; divide is iterative, all else single-cycle.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    state_e state, state_next;

    logic             accept, div_start, div_busy, div_done;
    logic [WIDTH-1:0] div_quotient;

    logic [WIDTH-1:0]   alu_result;
    logic [3:0]         alu_flags;
    logic               alu_carry, alu_ovf, alu_div0;
    logic [SHW-1:0]     shamt;
    logic [SHW:0]       rot_back;
    logic [WIDTH:0]     add_ext, sub_ext, shl_ext, shr_ext;
    logic [2*WIDTH-1:0] prod;

    assign accept    = in_valid && (state == ST_IDLE);
    assign div_start = accept && (op_e'(op) == OP_DIV) && (b != '0);

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (a),
        .divisor  (b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    assign shamt    = b[SHW-1:0];
    assign rot_back = (SHW+1)'(WIDTH) - {1'b0, shamt};
    assign add_ext  = {1'b0, a} + {1'b0, b};
    assign sub_ext  = {1'b0, a} - {1'b0, b};
    assign prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // Extra bit catches the last bit shifted out: MSB side for shl, LSB side for shr
    assign shl_ext  = {1'b0, a} << shamt;
    assign shr_ext  = {a, 1'b0} >> shamt;

    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        alu_div0   = 1'b0;
        unique case (op_e'(op))
            OP_ADD:  begin alu_result = add_ext[WIDTH-1:0]; alu_carry = add_ext[WIDTH]; end
            OP_SUB:  begin alu_result = sub_ext[WIDTH-1:0]; alu_carry = ~sub_ext[WIDTH]; end
            OP_MUL:  begin alu_result = prod[WIDTH-1:0]; alu_ovf = (prod[2*WIDTH-1:WIDTH] != '0); end
            OP_DIV:  begin alu_result = '1; alu_div0 = (b == '0); end
            OP_SHL:  begin alu_result = shl_ext[WIDTH-1:0]; alu_carry = (shamt != '0) && shl_ext[WIDTH]; end
            OP_SHR:  begin alu_result = shr_ext[WIDTH:1]; alu_carry = (shamt != '0) && shr_ext[0]; end
            OP_ROTL: alu_result = (a << shamt) | (a >> rot_back);
            OP_ROTR: alu_result = (a >> shamt) | (a << rot_back);
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            OP_NOR:  alu_result = ~(a | b);
            OP_NAND: alu_result = ~(a & b);
            OP_XOR:  alu_result = a ^ b;
            OP_XNOR: alu_result = ~(a ^ b);
            OP_GT:   alu_result = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   alu_result = {{(WIDTH-1){1'b0}}, (a == b)};
            default: alu_result = '0;
        endcase
        alu_flags             = '0;
        alu_flags[FLAG_ZERO]  = (alu_result == '0);
        alu_flags[FLAG_CARRY] = alu_carry;
        alu_flags[FLAG_OVF]   = alu_ovf;
        alu_flags[FLAG_DIV0]  = alu_div0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (in_valid) state_next = div_start ? ST_DIV : ST_HOLD;
            ST_DIV:  if (div_done) state_next = ST_HOLD;
            ST_HOLD: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
        end else if (accept && !div_start) begin
            result <= alu_result;
            flags  <= alu_flags;
        end else if ((state == ST_DIV) && div_busy && div_done) begin
            result           <= div_quotient;
            flags            <= '0;
            flags[FLAG_ZERO] <= (div_quotient == '0);
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu (WIDTH=32) against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    // Reference model; flags are {div0, ovf, carry, zero}, latency counts the accept edge as 1.
    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
        longint unsigned ux, uy, t;
        int s;
        logic c, v, d0;
        ux = x; uy = y; s = int'(y[4:0]);
        c = 0; v = 0; d0 = 0; lat = 1; r = 0;
        case (o)
            4'h0: begin t = ux + uy; r = t[31:0]; c = t[32]; end
            4'h1: begin r = x - y; c = (x >= y); end
            4'h2: begin t = ux * uy; r = t[31:0]; v = ((t >> 32) != 0); end
            4'h3: if (y == 0) begin r = 32'hFFFF_FFFF; d0 = 1; end
                  else begin r = x / y; lat = 33; end
            4'h4: begin r = x << s; c = (s > 0) ? x[32-s] : 1'b0; end
            4'h5: begin r = x >> s; c = (s > 0) ? x[s-1] : 1'b0; end
            4'h6: r = (s == 0) ? x : ((x << s) | (x >> (32 - s)));
            4'h7: r = (s == 0) ? x : ((x >> s) | (x << (32 - s)));
            4'h8: r = x & y;
            4'h9: r = x | y;
            4'hA: r = ~(x | y);
            4'hB: r = ~(x & y);
            4'hC: r = x ^ y;
            4'hD: r = ~(x ^ y);
            4'hE: r = (x > y) ? 32'd1 : 32'd0;
            default: r = (x == y) ? 32'd1 : 32'd0;
        endcase
        f = {d0, v, c, (r == 0)};
    endfunction

    // Issues one op with out_ready low and waits (bounded) for out_valid; leaves the result held.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic [3:0] f, output int lat,
                          output bit rdy_seen);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 4'($urandom);
        lat = 1; rdy_seen = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1;
            @(posedge clk); #1;
            lat++;
        end
        r = result; f = flags;
    endtask

    task automatic consume;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op = 4'h0; a = 32'h5; b = 32'h6;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        if (result !== 32'h0 || flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_regs: result=%h flags=%b required 0/0000", result, flags);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_vectors;
        logic [3:0]  vo[5] = '{4'h0, 4'h3, 4'h3, 4'h6, 4'h2};
        logic [31:0] va[5] = '{32'hFFFF_FFFF, 32'd100, 32'd5, 32'h8000_0001, 32'h0001_0000};
        logic [31:0] vb[5] = '{32'd1, 32'd7, 32'd0, 32'd4, 32'h0001_0000};
        logic [31:0] vr[5] = '{32'h0, 32'd14, 32'hFFFF_FFFF, 32'h0000_0018, 32'h0};
        logic [3:0]  vf[5] = '{4'b0011, 4'b0000, 4'b1000, 4'b0000, 4'b0101};
        int          vl[5] = '{1, 33, 1, 1, 1};
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        bit          rs;
        for (int i = 0; i < 5; i++) begin
            run_op(vo[i], va[i], vb[i], r, f, lat, rs);
            checks++;
            if (r !== vr[i] || f !== vf[i] || lat != vl[i]) begin
                errors++;
                $display("FAIL vector_%0d: result=%h flags=%b lat=%0d required %h/%b/%0d",
                         i, r, f, lat, vr[i], vf[i], vl[i]);
            end
            consume();
        end
    endtask

    task automatic test_div_latency;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        bit          rs;
        run_op(4'h3, 32'd100, 32'd7, r, f, lat, rs);
        checks++;
        if (lat != 33 || rs || r !== 32'd14) begin
            errors++;
            $display("FAIL div_latency: lat=%0d in_ready_seen=%0d result=%0d required 33/0/14", lat, rs, r);
        end
        consume();
    endtask

    task automatic test_random;
        logic [3:0]  o;
        logic [31:0] x, y, r, er;
        logic [3:0]  f, ef;
        int          lat, el;
        bit          rs;
        for (int i = 0; i < 160; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = $urandom_range(0, 40);
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) x = y;
            model(o, x, y, er, ef, el);
            run_op(o, x, y, r, f, lat, rs);
            checks++;
            if (r !== er || f !== ef || lat != el || rs) begin
                errors++;
                $display("FAIL random_op%h a=%h b=%h: result=%h flags=%b lat=%0d rdy=%0d required %h/%b/%0d/0",
                         o, x, y, r, f, lat, rs, er, ef, el);
            end
            consume();
        end
    endtask

    task automatic test_hold_stall;
        logic [31:0] r, er;
        logic [3:0]  f, ef;
        int          lat, el;
        bit          rs, bad;
        model(4'h1, 32'd3, 32'd9, er, ef, el);
        run_op(4'h1, 32'd3, 32'd9, r, f, lat, rs);
        checks++;
        if (r !== er || f !== ef) begin
            errors++;
            $display("FAIL stall_first: result=%h flags=%b required %h/%b", r, f, er, ef);
        end
        bad = 0;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (result !== er || flags !== ef || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_stable: result=%h flags=%b in_ready=%b required %h/%b/0", result, flags, in_ready, er, ef);
        end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r, er;
        logic [3:0]  f, ef;
        int          lat, el;
        bit          rs;
        run_op(4'hC, 32'hAAAA_0000, 32'h0F0F_0F0F, r, f, lat, rs);
        model(4'h9, 32'h1200_0000, 32'h0000_0034, er, ef, el);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op = 4'h9; a = 32'h1200_0000; b = 32'h0000_0034;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_accept: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== er || flags !== ef) begin
            errors++;
            $display("FAIL b2b_second: out_valid=%b result=%h flags=%b required 1/%h/%b", out_valid, result, flags, er, ef);
        end
        consume();
    endtask

    task automatic test_reset_abort;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        bit          rs, rose;
        @(negedge clk);
        op = 4'h3; a = $urandom; b = $urandom_range(1, 1000); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rose = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) rose = 1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || flags !== 4'h0) begin
            errors++;
            $display("FAIL abort_reset: out_valid=%b in_ready=%b result=%h flags=%b required 0/1/0/0",
                     out_valid, in_ready, result, flags);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) rose = 1;
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL abort_no_output: out_valid=1 required 0");
        end
        run_op(4'h8, 32'hF0, 32'h3C, r, f, lat, rs);
        checks++;
        if (r !== 32'h30 || f !== 4'b0000 || lat != 1) begin
            errors++;
            $display("FAIL abort_followup: result=%h flags=%b lat=%0d required 30/0000/1", r, f, lat);
        end
        consume();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        test_reset();
        test_vectors();
        test_div_latency();
        test_hold_stall();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
